// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 VGA raster timing. A clock divider produces a
//                pixel-rate strobe, horizontal/vertical counters walk the
//                raster, stage 1 registers x/y/isdisplayed and stage 2
//                registers active-low hsync/vsync one clk later so the sync
//                pins line up with the drawer's registered RGB.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int HACTIVE = 640,
   parameter int HFP     = 16,
   parameter int HSYNC   = 96,
   parameter int HBP     = 48,
   parameter int VACTIVE = 480,
   parameter int VFP     = 10,
   parameter int VSYNC   = 2,
   parameter int VBP     = 33,
   parameter int CLKDIV  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       isdisplayed,
   output logic       hsync,
   output logic       vsync,
   output logic       pixel_tick,
   output logic       frame_end
);

   // Raster geometry; HTOTAL and VTOTAL must not exceed 1024 so the
   // 10-bit counters can hold every position.
   localparam int c_htotal = HACTIVE + HFP + HSYNC + HBP;
   localparam int c_vtotal = VACTIVE + VFP + VSYNC + VBP;

   localparam logic [9:0]  c_h_last   = 10'(c_htotal - 1);
   localparam logic [9:0]  c_v_last   = 10'(c_vtotal - 1);
   // Active-region and sync-window bounds are compared at 11 bits because
   // the upper bounds may equal 1024.
   localparam logic [10:0] c_hactive  = 11'(HACTIVE);
   localparam logic [10:0] c_vactive  = 11'(VACTIVE);
   localparam logic [10:0] c_hs_start = 11'(HACTIVE + HFP);
   localparam logic [10:0] c_hs_end   = 11'(HACTIVE + HFP + HSYNC);
   localparam logic [10:0] c_vs_start = 11'(VACTIVE + VFP);
   localparam logic [10:0] c_vs_end   = 11'(VACTIVE + VFP + VSYNC);

   // Divider width: a one-bit register that never leaves zero when CLKDIV=1.
   localparam int                 c_div_w    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLKDIV - 1);

   logic [c_div_w-1:0] div_q, div_d;
   logic               tick_q, tick_d;
   logic [9:0]         h_q, h_d;
   logic [9:0]         v_q, v_d;
   logic [9:0]         x_q, y_q;
   logic               disp_q, disp_d;
   logic               hs_raw, vs_raw;
   logic               hsync_q, vsync_q;
   logic               fe_q, fe_d;

   // Next-state for divider, pixel strobe, raster counters and frame pulse.
   always_comb begin
      div_d  = (div_q == c_div_last) ? '0 : div_q + 1'b1;
      tick_d = (div_q == c_div_last);
      h_d    = h_q;
      v_d    = v_q;
      fe_d   = tick_q && (h_q == c_h_last) && (v_q == c_v_last);
      if (tick_q) begin
         if (h_q == c_h_last) begin
            h_d = '0;
            v_d = (v_q == c_v_last) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Active-video qualifier from the raw counters, registered in stage 1.
   always_comb begin
      disp_d = ({1'b0, h_q} < c_hactive) && ({1'b0, v_q} < c_vactive);
   end

   // Sync windows decoded from the stage-1 coordinates (low inside window).
   always_comb begin
      hs_raw = !(({1'b0, x_q} >= c_hs_start) && ({1'b0, x_q} < c_hs_end));
      vs_raw = !(({1'b0, y_q} >= c_vs_start) && ({1'b0, y_q} < c_vs_end));
   end

   // Divider, counters, stage-1 and stage-2 registers; reset forces sync high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q   <= '0;
         tick_q  <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         disp_q  <= 1'b0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fe_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         tick_q  <= tick_d;
         h_q     <= h_d;
         v_q     <= v_d;
         x_q     <= h_q;
         y_q     <= v_q;
         disp_q  <= disp_d;
         hsync_q <= hs_raw;
         vsync_q <= vs_raw;
         fe_q    <= fe_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign isdisplayed = disp_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign pixel_tick  = tick_q;
   assign frame_end   = fe_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Instance A uses the
//                full 640x480 geometry at CLKDIV=2, instance B a reduced
//                geometry at CLKDIV=1 so whole frames fit in a short run.
//                Expected outputs come from a closed-form model: the pixel
//                count elapsed since reset release, split into line/column.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
   localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33, A_D = 2;
   localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
   localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;

   localparam int B_HA = 16, B_HFP = 4, B_HS = 6, B_HBP = 6;
   localparam int B_VA = 12, B_VFP = 3, B_VS = 2, B_VBP = 4, B_D = 1;
   localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;   // 32
   localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;   // 21

   logic clk = 1'b0;
   logic rst_a_n, rst_b_n;
   logic [9:0] xa, ya, xb, yb;
   logic da, hsa, vsa, pta, fea;
   logic db, hsb, vsb, ptb, feb;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .HACTIVE(A_HA), .HFP(A_HFP), .HSYNC(A_HS), .HBP(A_HBP),
      .VACTIVE(A_VA), .VFP(A_VFP), .VSYNC(A_VS), .VBP(A_VBP), .CLKDIV(A_D)
   ) u_a (
      .clk(clk), .reset_n(rst_a_n), .x(xa), .y(ya), .isdisplayed(da),
      .hsync(hsa), .vsync(vsa), .pixel_tick(pta), .frame_end(fea)
   );

   vga_timing_gen #(
      .HACTIVE(B_HA), .HFP(B_HFP), .HSYNC(B_HS), .HBP(B_HBP),
      .VACTIVE(B_VA), .VFP(B_VFP), .VSYNC(B_VS), .VBP(B_VBP), .CLKDIV(B_D)
   ) u_b (
      .clk(clk), .reset_n(rst_b_n), .x(xb), .y(yb), .isdisplayed(db),
      .hsync(hsb), .vsync(vsb), .pixel_tick(ptb), .frame_end(feb)
   );

   // Clock edges seen since each instance left reset.
   int n_a, n_b;
   always @(posedge clk or negedge rst_a_n) if (!rst_a_n) n_a <= 0; else n_a <= n_a + 1;
   always @(posedge clk or negedge rst_b_n) if (!rst_b_n) n_b <= 0; else n_b <= n_b + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Pixel ticks consumed by the counters after n edges: the strobe is high
   // after edges D, 2D, ... and each strobe advances the counters one edge later.
   function automatic int pix(input int n, input int d);
      return (n >= 1) ? (n - 1) / d : 0;
   endfunction
   function automatic int hpos(input int n, input int d, input int ht);
      return pix(n, d) % ht;
   endfunction
   function automatic int vpos(input int n, input int d, input int ht, input int vt);
      return (pix(n, d) / ht) % vt;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag, input int n, input int d,
                              input int ht, input int vt, input int ha, input int va,
                              input int hs0, input int hs1, input int vs0, input int vs1,
                              input logic [9:0] ox, input logic [9:0] oy, input logic od,
                              input logic ohs, input logic ovs, input logic opt, input logic ofe);
      int ex, ey, x2, y2;
      logic ed, ehs, evs, ept, efe;
      ex  = hpos(n - 1, d, ht);
      ey  = vpos(n - 1, d, ht, vt);
      x2  = hpos(n - 2, d, ht);
      y2  = vpos(n - 2, d, ht, vt);
      ed  = (n >= 1) && (ex < ha) && (ey < va);
      ehs = !((n >= 1) && (x2 >= hs0) && (x2 < hs1));
      evs = !((n >= 1) && (y2 >= vs0) && (y2 < vs1));
      ept = (n >= 1) && (n % d == 0);
      efe = (n >= 2) && ((n - 1) % d == 0) && (pix(n - 1, d) % (ht * vt) == ht * vt - 1);
      chk({tag, "_x"},    32'(ox),  32'(ex));
      chk({tag, "_y"},    32'(oy),  32'(ey));
      chk({tag, "_disp"}, 32'(od),  32'(ed));
      chk({tag, "_hs"},   32'(ohs), 32'(ehs));
      chk({tag, "_vs"},   32'(ovs), 32'(evs));
      chk({tag, "_pt"},   32'(opt), 32'(ept));
      chk({tag, "_fe"},   32'(ofe), 32'(efe));
   endtask

   task automatic check_a();
      check_model("A", n_a, A_D, A_HT, A_VT, A_HA, A_VA, A_HA + A_HFP, A_HA + A_HFP + A_HS,
                  A_VA + A_VFP, A_VA + A_VFP + A_VS, xa, ya, da, hsa, vsa, pta, fea);
   endtask
   task automatic check_b();
      check_model("B", n_b, B_D, B_HT, B_VT, B_HA, B_VA, B_HA + B_HFP, B_HA + B_HFP + B_HS,
                  B_VA + B_VFP, B_VA + B_VFP + B_VS, xb, yb, db, hsb, vsb, ptb, feb);
   endtask

   function automatic int qget(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   // Measurement state for directed timing properties.
   int   cyc = 0;
   bit   meas_on = 0;
   logic [9:0] pxa = '0, pya = '0;
   logic pda = 0, phsa = 1, pvsb = 1;
   int   x656_cyc = -1000, disp_run = 0, hs_run = 0, vs_run = 0;
   bit   wrap_seen = 0, fe_next = 0;
   int   disp_runs[$], hs_runs[$], hs_falls[$], hs_gap[$], vs_runs[$], fe_cycs[$];

   // One clock: sample at the falling edge, compare both instances to the
   // model, then collect run lengths and edge positions.
   task automatic step();
      @(negedge clk);
      cyc++;
      check_a();
      check_b();
      if (meas_on) begin
         if (xa == 10'd656 && pxa != 10'd656) x656_cyc = cyc;
         if (da) disp_run++;
         else if (pda) begin disp_runs.push_back(disp_run); disp_run = 0; end
         if (!hsa) hs_run++;
         if (!hsa && phsa) begin hs_falls.push_back(cyc); hs_gap.push_back(cyc - x656_cyc); end
         if (hsa && !phsa) begin hs_runs.push_back(hs_run); hs_run = 0; end
         if (pxa == 10'd799 && pya == 10'd5 && xa != 10'd799) begin
            chk("A_wrap_x", 32'(xa), 0);
            chk("A_wrap_y", 32'(ya), 6);
            chk("A_wrap_disp", 32'(da), 1);
            wrap_seen = 1;
         end
         if (!vsb) vs_run++;
         if (vsb && !pvsb) begin vs_runs.push_back(vs_run); vs_run = 0; end
         if (feb) begin
            fe_cycs.push_back(cyc);
            chk("B_fe_x", 32'(xb), B_HT - 1);
            chk("B_fe_y", 32'(yb), B_VT - 1);
            fe_next = 1;
         end else if (fe_next) begin
            chk("B_after_fe_x", 32'(xb), 0);
            chk("B_after_fe_y", 32'(yb), 0);
            fe_next = 0;
         end
      end
      pxa = xa; pya = ya; pda = da; phsa = hsa; pvsb = vsb;
   endtask

   initial begin
      int tgt, hold;
      bit found;

      // Reset values while held low.
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (5) step();
      chk("rst_hs_a", 32'(hsa), 1);
      chk("rst_vs_a", 32'(vsa), 1);

      // Release and run several lines of A and two-plus frames of B.
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      meas_on = 1;
      step();
      chk("A_first_disp", 32'(da), 1);
      chk("A_first_pt", 32'(pta), 0);
      step();
      chk("A_second_pt", 32'(pta), 1);
      repeat (6 * 1600 + 200 + $urandom_range(0, 400)) step();
      meas_on = 0;

      chk("A_disp_len",     32'(qget(disp_runs, 1)), 1280);
      chk("A_hs_low0",      32'(qget(hs_runs, 0)), 192);
      chk("A_hs_low1",      32'(qget(hs_runs, 1)), 192);
      chk("A_hs_after_656", 32'(qget(hs_gap, 0)), 1);
      chk("A_line_period",  32'(qget(hs_falls, 1) - qget(hs_falls, 0)), 1600);
      chk("A_wrap_seen",    32'(wrap_seen), 1);
      chk("B_vs_low",       32'(qget(vs_runs, 0)), B_VS * B_HT);
      chk("B_fe_period",    32'(qget(fe_cycs, 1) - qget(fe_cycs, 0)), B_HT * B_VT);

      // Mid-line reset of A while hsync is low.
      found = 0;
      for (int i = 0; i < 4000 && !found; i++) begin
         step();
         if (!hsa && ya >= 10'd1) found = 1;
      end
      chk("A_wait_hs_low", 32'(found), 1);
      #($urandom_range(1, 3));
      rst_a_n = 1'b0;
      #1;
      chk("A_async_hs", 32'(hsa), 1);
      chk("A_async_x",  32'(xa), 0);
      chk("A_async_y",  32'(ya), 0);
      chk("A_async_disp", 32'(da), 0);
      hold = $urandom_range(2, 5);
      repeat (hold) step();
      rst_a_n = 1'b1;
      step();
      chk("A_rel_disp", 32'(da), 1);
      chk("A_rel_pt", 32'(pta), 0);
      step();
      chk("A_rel_pt2", 32'(pta), 1);
      repeat (2000 + $urandom_range(0, 200)) step();

      // Mid-frame reset of B while hsync is low on a randomly chosen line.
      tgt = $urandom_range(2, B_VT - 2);
      found = 0;
      for (int i = 0; i < 4000 && !found; i++) begin
         step();
         if (!hsb && yb == 10'(tgt)) found = 1;
      end
      chk("B_wait_hs_low", 32'(found), 1);
      #($urandom_range(1, 3));
      rst_b_n = 1'b0;
      #1;
      chk("B_async_hs", 32'(hsb), 1);
      chk("B_async_x",  32'(xb), 0);
      chk("B_async_y",  32'(yb), 0);
      hold = $urandom_range(2, 5);
      repeat (hold) step();
      rst_b_n = 1'b1;
      step();
      chk("B_rel_pt", 32'(ptb), 1);
      chk("B_rel_disp", 32'(db), 1);
      repeat (2 * B_HT * B_VT + $urandom_range(0, 100)) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
